// File: rtl/fp16_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined FP16 multiplier among NUM_REQ requesters.
// Define FP16_MUL_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no rotating pointer).
module fp16_mul_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      in_Req,
  input  logic [16*NUM_REQ-1:0]   in_A,
  input  logic [16*NUM_REQ-1:0]   in_B,
  output logic [NUM_REQ-1:0]      out_Grant,
  output logic [15:0]             mul_A,
  output logic [15:0]             mul_B,
  output logic                    mul_En,
  input  logic [15:0]             mul_Out,
  output logic [15:0]             out_Result,
  output logic [NUM_REQ-1:0]      out_Valid,
  output logic                    out_Busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ-1);

  // Handshake: requester i holds in_Req[i] and its operands until out_Grant[i]=1 at a
  // rising edge; the operation issues on that edge. Results carry no back-pressure.
  logic [IDX_W-1:0] startIdx;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] searchIdx;
  logic [IDX_W:0]   searchSum;
  logic             anyGrant;

`ifdef FP16_MUL_ARB_FIXED_PRIO_EN
  assign startIdx = '0;
`else
  logic [IDX_W-1:0] rrPtr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rrPtr <= '0;
    end else if (anyGrant) begin
      rrPtr <= (winner == LAST_IDX) ? '0 : winner + IDX_W'(1);
    end
  end

  assign startIdx = rrPtr;
`endif

  // Scan upward from startIdx with wrap; the first asserted request wins.
  always_comb begin
    anyGrant  = 1'b0;
    winner    = '0;
    searchSum = '0;
    searchIdx = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      searchSum = {1'b0, startIdx} + (IDX_W+1)'(off);
      if (searchSum >= NUM_REQ_W) searchSum = searchSum - NUM_REQ_W;
      searchIdx = searchSum[IDX_W-1:0];
      if (!anyGrant && in_Req[searchIdx]) begin
        anyGrant = 1'b1;
        winner   = searchIdx;
      end
    end
  end

  always_comb begin
    out_Grant = '0;
    mul_A     = '0;
    mul_B     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (anyGrant && winner == IDX_W'(i)) begin
        out_Grant[i] = 1'b1;
        mul_A        = in_A[16*i +: 16];
        mul_B        = in_B[16*i +: 16];
      end
    end
  end

  assign mul_En = anyGrant;

  // Tag pipeline shifts every cycle so idle gaps line up with the multiplier's stages.
  logic [MUL_LATENCY-1:0] pipeValid;
  logic [IDX_W-1:0]       pipeTag [MUL_LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipeValid <= '0;
      for (int s = 0; s < MUL_LATENCY; s++) pipeTag[s] <= '0;
    end else begin
      pipeValid[0] <= anyGrant;
      pipeTag[0]   <= winner;
      for (int s = 1; s < MUL_LATENCY; s++) begin
        pipeValid[s] <= pipeValid[s-1];
        pipeTag[s]   <= pipeTag[s-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_Result <= '0;
      out_Valid  <= '0;
    end else begin
      out_Valid <= '0;
      if (pipeValid[MUL_LATENCY-1]) begin
        out_Result <= mul_Out;
        for (int i = 0; i < NUM_REQ; i++) begin
          out_Valid[i] <= (pipeTag[MUL_LATENCY-1] == IDX_W'(i));
        end
      end
    end
  end

  assign out_Busy = (|pipeValid) | (|out_Valid);

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// Bench for fp16_mul_arbiter: directed scenarios plus random traffic against a
// cycle-indexed reference model of arbitration order and result return.
module tb_fp16_mul_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int MUL_LATENCY = 2;
  localparam int IDX_W       = $clog2(NUM_REQ);
  localparam int EW          = 32 + NUM_REQ;

  // Clock/reset and DUT signals
  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    in_Req;
  logic [16*NUM_REQ-1:0] in_A, in_B;
  logic [NUM_REQ-1:0]    out_Grant, out_Valid;
  logic [15:0]           mul_A, mul_B, mul_Out, out_Result;
  logic                  mul_En, out_Busy;

  logic [15:0] opA [NUM_REQ];
  logic [15:0] opB [NUM_REQ];

  always #5 clk = ~clk;

  always_comb begin
    in_A = '0;
    in_B = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      in_A[16*i +: 16] = opA[i];
      in_B[16*i +: 16] = opB[i];
    end
  end

  // Two-cycle multiplier stand-in: product is A^B; mid stage holds when not enabled.
  logic [15:0] stubMid, stubOut;
  always @(posedge clk) begin
    if (mul_En) stubMid <= mul_A ^ mul_B;
    stubOut <= stubMid;
  end
  assign mul_Out = stubOut;

  fp16_mul_arbiter #(.NUM_REQ(NUM_REQ), .MUL_LATENCY(MUL_LATENCY)) dut (
    .clk(clk), .rst(rst), .in_Req(in_Req), .in_A(in_A), .in_B(in_B),
    .out_Grant(out_Grant), .mul_A(mul_A), .mul_B(mul_B), .mul_En(mul_En),
    .mul_Out(mul_Out), .out_Result(out_Result), .out_Valid(out_Valid), .out_Busy(out_Busy)
  );

  // Scoreboard: each entry is {due cycle, owner one-hot, product}
  logic [EW-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int mdlPtr = 0;
  logic [15:0] mdlResult = '0;

  logic [NUM_REQ-1:0] sampledGrant, sampledValid;
  logic [15:0]        sampledResult;
  logic               sampledEn, sampledBusy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    mdlResult = '0;
    mdlPtr = 0;
  endtask

  task automatic check_cycle(output int granted);
    logic [EW-1:0]      e;
    logic [NUM_REQ-1:0] expValid, expGrant;
    bit                 popped;
    int                 start, win, idx;
    expValid = '0;
    popped = 1'b0;
    if (exp_q.size() > 0 && exp_q[0][EW-1 -: 16] == cyc[15:0]) begin
      e = exp_q.pop_front();
      expValid = e[16 +: NUM_REQ];
      mdlResult = e[15:0];
      popped = 1'b1;
    end
    sampledValid  = out_Valid;
    sampledResult = out_Result;
    sampledBusy   = out_Busy;
    sampledGrant  = out_Grant;
    sampledEn     = mul_En;
    check("out_valid", 32'(out_Valid), 32'(expValid));
    check("out_result", 32'(out_Result), 32'(mdlResult));
    check("out_busy", 32'(out_Busy), 32'(popped || exp_q.size() != 0));

`ifdef FP16_MUL_ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = mdlPtr;
`endif
    win = -1;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (start + off) % NUM_REQ;
      if (win < 0 && in_Req[IDX_W'(idx)]) win = idx;
    end
    expGrant = (win >= 0) ? (NUM_REQ'(1) << win) : '0;
    check("grant", 32'(out_Grant), 32'(expGrant));
    check("mul_en", 32'(mul_En), 32'(win >= 0));
    check("mul_a", 32'(mul_A), (win >= 0) ? 32'(opA[IDX_W'(win)]) : 32'(0));
    check("mul_b", 32'(mul_B), (win >= 0) ? 32'(opB[IDX_W'(win)]) : 32'(0));
    if (win >= 0) begin
      exp_q.push_back({16'(cyc + MUL_LATENCY + 1), expGrant, opA[IDX_W'(win)] ^ opB[IDX_W'(win)]});
      mdlPtr = (win + 1) % NUM_REQ;
    end
    granted = win;
  endtask

  // Driver: present requests for one cycle, check at the falling edge, then advance.
  task automatic step(input logic [NUM_REQ-1:0] req);
    int g;
    in_Req = req;
    @(negedge clk);
    check_cycle(g);
    @(posedge clk);
    #1;
    cyc++;
    if (g >= 0) begin
      opA[IDX_W'(g)] = 16'($urandom);
      opB[IDX_W'(g)] = 16'($urandom);
    end
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    model_reset();
    step('0);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    in_Req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      opA[i] = 16'($urandom);
      opB[i] = 16'($urandom);
    end
    @(negedge clk);
    check("rst_valid", 32'(out_Valid), 32'(0));
    check("rst_result", 32'(out_Result), 32'(0));
    check("rst_busy", 32'(out_Busy), 32'(0));
    check("rst_grant", 32'(out_Grant), 32'(0));
    check("rst_mul_en", 32'(mul_En), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

`ifndef FP16_MUL_ARB_FIXED_PRIO_EN
    // Single issue from requester 2
    opA[2] = 16'h3E00;
    opB[2] = 16'h4000;
    step(4'b0100);
    check("single_grant", 32'(sampledGrant), 32'(4'b0100));
    check("single_en", 32'(sampledEn), 32'(1));
    step('0);
    step('0);
    check("single_early", 32'(sampledValid), 32'(0));
    step('0);
    check("single_valid", 32'(sampledValid), 32'(4'b0100));
    check("single_result", 32'(sampledResult), 32'(16'h7E00));
    step('0);

    // Fairness: grant 3 first so the pointer sits at 0
    step(4'b1000);
    for (int k = 0; k < 8; k++) begin
      step(4'b1111);
      check("rr_grant", 32'(sampledGrant), 32'(NUM_REQ'(1) << (k % 4)));
      if (k >= 3) check("rr_valid", 32'(sampledValid), 32'(NUM_REQ'(1) << ((k - 3) % 4)));
    end
    for (int k = 8; k < 11; k++) begin
      step('0);
      check("rr_drain", 32'(sampledValid), 32'(NUM_REQ'(1) << ((k - 3) % 4)));
    end

    // Partial contention after granting 0
    step(4'b0001);
    check("part_g0", 32'(sampledGrant), 32'(4'b0001));
    step(4'b1001);
    check("part_g3", 32'(sampledGrant), 32'(4'b1000));
    step(4'b1001);
    check("part_g0b", 32'(sampledGrant), 32'(4'b0001));
    repeat (4) step('0);

    // Gaps between issues
    step(4'b0010);
    step('0);
    step('0);
    step(4'b0100);
    check("gap_valid1", 32'(sampledValid), 32'(4'b0010));
    step('0);
    step('0);
    step('0);
    check("gap_valid2", 32'(sampledValid), 32'(4'b0100));
    step('0);
    check("gap_busy", 32'(sampledBusy), 32'(0));

    // Reset with three operations in flight
    repeat (3) step(4'b1111);
    reset_pulse();
    check("rif_valid", 32'(sampledValid), 32'(0));
    check("rif_result", 32'(sampledResult), 32'(0));
    check("rif_busy", 32'(sampledBusy), 32'(0));
    for (int k = 0; k < 4; k++) begin
      step('0);
      check("rif_valid_after", 32'(sampledValid), 32'(0));
      check("rif_busy_after", 32'(sampledBusy), 32'(0));
    end
    step(4'b1111);
    check("rif_first_grant", 32'(sampledGrant), 32'(4'b0001));
`else
    for (int k = 0; k < 6; k++) begin
      step(4'b1111);
      check("fixed_grant", 32'(sampledGrant), 32'(4'b0001));
    end
`endif

    // Random traffic with occasional reset
    for (int n = 0; n < 400; n++) begin
      if (n % 97 == 50) begin
        reset_pulse();
      end else if ($urandom_range(0, 4) == 0) begin
        step('0);
      end else begin
        step(NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1)));
      end
    end
    repeat (5) step('0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp16_mul_arbiter.md
Name: fp16_mul_arbiter

Overview:
- Round-robin arbiter that shares one 2-stage FP16 multiplier among NUM_REQ requesters in the neuron datapath.
- Grants at most one operand pair per cycle and drives the multiplier's operand and enable inputs.
- Tracks in-flight operations in its own tag/valid pipeline. Returns each product to the requester that issued it.
- Ignores the multiplier's ready output, because that output stays high once set.

Parameters:
- NUM_REQ, 4: number of requesters; range 2..8.
- MUL_LATENCY, 2: cycles from the mul_En edge until mul_Out holds the product.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_Req  in  NUM_REQ  per-requester request level.
- in_A  in  16*NUM_REQ  operand A, flat; requester i uses bits [16i+15:16i].
- in_B  in  16*NUM_REQ  operand B, same packing as in_A.
- out_Grant  out  NUM_REQ  one-hot combinational grant, same cycle as the request.
- mul_A  out  16  operand A to the multiplier; muxed from the granted requester.
- mul_B  out  16  operand B to the multiplier.
- mul_En  out  1  multiplier enable; high exactly when any grant is high.
- mul_Out  in  16  multiplier result.
- out_Result  out  16  registered product.
- out_Valid  out  NUM_REQ  registered one-hot; marks the owner of out_Result for one cycle.
- out_Busy  out  1  high while any operation is in flight.

Behaviour:
- Clock and reset: one clock domain (clk). Reset rst is asynchronous and active-high.
- Handshake:
  - A requester holds in_Req and its operands stable until it sees out_Grant[i]=1 at a rising edge.
  - The operation is issued at that edge.
  - The requester may keep in_Req high to issue back-to-back operations.
- Arbitration:
  - rr_ptr is a log2(NUM_REQ)-bit register.
  - Search starts at index rr_ptr and proceeds upward, wrapping from NUM_REQ-1 to 0.
  - The first asserted in_Req wins.
  - On a grant, rr_ptr becomes (winner+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Datapath muxing:
  - mul_A and mul_B carry the winner's operands.
  - With no grant they are 0 and mul_En=0.
- Issue pipeline:
  - A shift register of MUL_LATENCY stages, each holding {valid, tag}.
  - Stage 0 loads {mul_En, winner index} every cycle.
  - When the last stage is valid, the block captures mul_Out into out_Result and sets out_Valid = onehot(tag) at the next edge.
  - Grant-to-out_Valid latency is MUL_LATENCY+1 cycles (3 by default).
- Throughput and ordering:
  - Full throughput: one result per cycle.
  - Results return in issue order.
  - out_Result holds its value between valid pulses.
  - out_Valid is high for exactly one cycle per issued operation.
- out_Busy: OR of all pipeline valid bits and the output-stage valid.
- Idle gaps: when mul_En=0 between issues, the multiplier holds its mid stage. The tag pipeline still advances, so no result is lost or duplicated.
- Reset values: rr_ptr=0, all pipeline valids=0, out_Result=16'h0000, out_Valid=0, out_Busy=0. Combinational outputs follow from these (out_Grant=0 unless in_Req is high).
- Reset mid-operation: all in-flight operations are discarded. No out_Valid is asserted for them after rst falls. The first grant after reset starts its search at requester 0.
- No request: no grant and no state change except pipeline shift.
- Single requester: granted every cycle it requests.
- No back-pressure: requesters must accept out_Valid unconditionally.

Optional Feature:
- Macro: FP16_MUL_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest asserted index always wins, and rr_ptr is not implemented.
- Undefined (default): round-robin as described above.
- Latency, handshake and result routing are identical in both modes.

Test Plan:
- Single issue: reset, then in_Req=4'b0100 with A=16'h3E00, B=16'h4000 for one cycle. Expected: out_Grant=4'b0100 in that cycle, mul_En=1; out_Valid=4'b0100 exactly 3 cycles later; out_Result equals the bench's 2-cycle stub output (A^B = 16'h7E00).
- Round-robin fairness: hold in_Req=4'b1111 for 8 cycles. Expected: grant order 0,1,2,3,0,1,2,3; out_Valid follows the same order, one per cycle, starting 3 cycles after the first grant.
- Contention with a partial set: rr_ptr=1 (after granting 0), in_Req=4'b1001. Expected: grant to 3, then 0; requester 0 is not granted twice in a row.
- Gaps in issue: issue from requester 1, idle 2 cycles, issue from requester 2. Expected: two out_Valid pulses (4'b0010 then 4'b0100), 3 cycles after each grant, with the correct stub results; out_Busy drops to 0 once both have returned.
- Reset in flight: issue 3 back-to-back operations, assert rst on the cycle after the last grant. Expected: out_Valid=0, out_Result=0 and out_Busy=0 immediately and for the following 4 cycles; the next grant goes to requester 0.
- Fixed-priority build (macro defined): in_Req=4'b1111 held. Expected: requester 0 granted every cycle; requesters 1–3 never granted.
